// File: rtl/ball_engine.sv
// Pong ball controller: owns ball position, direction, speed, serve sequencing
// and point detection. Motion advances once per frame tick.
module ball_engine #(
  parameter int unsigned SCREEN_W         = 640,
  parameter int unsigned SCREEN_H         = 480,
  parameter int unsigned BALL_SIZE        = 10,
  parameter int unsigned PADDLE_W         = 30,
  parameter int unsigned PADDLE_H         = 200,
  parameter int unsigned START_X          = 310,
  parameter int unsigned START_Y          = 235,
  parameter int unsigned MAX_SPEED        = 4,
  parameter int unsigned HITS_PER_SPEEDUP = 4,
  parameter int unsigned SERVE_DELAY      = 60
) (
  input  logic       game_clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       serve,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_x,
  input  logic [9:0] p2_y,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       point_p1,
  output logic       point_p2,
  output logic [3:0] speed,
  output logic [7:0] rally,
  output logic [1:0] state
);

  localparam int unsigned HitW = (HITS_PER_SPEEDUP > 0) ? $clog2(HITS_PER_SPEEDUP + 1) : 1;
  localparam int unsigned DlyW = (SERVE_DELAY > 0) ? $clog2(SERVE_DELAY + 1) : 1;

  // All geometry is compared in 11 bits so sums near the screen edge never wrap.
  localparam logic [10:0] BallW  = 11'(BALL_SIZE);
  localparam logic [10:0] PadW   = 11'(PADDLE_W);
  localparam logic [10:0] PadH   = 11'(PADDLE_H);
  localparam logic [10:0] XMax   = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] YMax   = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0]  StartX = 10'(START_X);
  localparam logic [9:0]  StartY = 10'(START_Y);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StServeWait = 2'd1,
    StPlay      = 2'd2,
    StScored    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              dx_q, dx_d, dy_q, dy_d;
  logic              serve_dir_q, serve_dir_d;
  logic [3:0]        speed_q, speed_d;
  logic [7:0]        rally_q, rally_d;
  logic [HitW-1:0]   hit_cnt_q, hit_cnt_d;
  logic [DlyW-1:0]   delay_cnt_q, delay_cnt_d;
  logic              point_p1_q, point_p1_d, point_p2_q, point_p2_d;

  logic [10:0] x_w, y_w, spd_w, p1x_w, p1y_w, p2x_w, p2y_w;
  logic        p1_y_ovl, p2_y_ovl, p1_hit, p2_hit, goal_l, goal_r;

  assign x_w   = {1'b0, x_q};
  assign y_w   = {1'b0, y_q};
  assign spd_w = {7'b0, speed_q};
  assign p1x_w = {1'b0, p1_x};
  assign p1y_w = {1'b0, p1_y};
  assign p2x_w = {1'b0, p2_x};
  assign p2y_w = {1'b0, p2_y};

  assign p1_y_ovl = (y_w + BallW > p1y_w) && (y_w < p1y_w + PadH);
  assign p2_y_ovl = (y_w + BallW > p2y_w) && (y_w < p2y_w + PadH);
  assign p1_hit   = !dx_q && (x_w <= p1x_w + PadW) && (x_w + BallW > p1x_w) && p1_y_ovl;
  assign p2_hit   = dx_q && (x_w + BallW >= p2x_w) && (x_w < p2x_w + PadW) && p2_y_ovl;
  assign goal_l   = !dx_q && (x_w < spd_w);
  assign goal_r   = dx_q && (x_w + spd_w > XMax);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    serve_dir_d = serve_dir_q;
    speed_d     = speed_q;
    rally_d     = rally_q;
    hit_cnt_d   = hit_cnt_q;
    delay_cnt_d = delay_cnt_q;
    point_p1_d  = 1'b0;
    point_p2_d  = 1'b0;

    case (state_q)
      StIdle: begin
        x_d = StartX;
        y_d = StartY;
        if (serve) state_d = StServeWait;
      end

      StServeWait: begin
        if (tick) begin
          if (32'(delay_cnt_q) + 32'd1 >= SERVE_DELAY) begin
            state_d     = StPlay;
            delay_cnt_d = '0;
          end else begin
            delay_cnt_d = delay_cnt_q + DlyW'(1);
          end
        end
      end

      StPlay: begin
        if (tick) begin
          // Paddles take priority over goals; the ball is snapped flush to the paddle face.
          if (p1_hit) begin
            dx_d = 1'b1;
            x_d  = 10'(p1x_w + PadW);
          end else if (p2_hit) begin
            dx_d = 1'b0;
            x_d  = 10'(p2x_w - BallW);
          end else if (goal_l) begin
            x_d         = '0;
            point_p2_d  = 1'b1;
            serve_dir_d = 1'b0;
            state_d     = StScored;
          end else if (goal_r) begin
            x_d         = 10'(XMax);
            point_p1_d  = 1'b1;
            serve_dir_d = 1'b1;
            state_d     = StScored;
          end else if (dx_q) begin
            x_d = 10'(x_w + spd_w);
          end else begin
            x_d = 10'(x_w - spd_w);
          end

          if (!dy_q && (y_w < spd_w)) begin
            y_d  = '0;
            dy_d = 1'b1;
          end else if (dy_q && (y_w + spd_w > YMax)) begin
            y_d  = 10'(YMax);
            dy_d = 1'b0;
          end else if (dy_q) begin
            y_d = 10'(y_w + spd_w);
          end else begin
            y_d = 10'(y_w - spd_w);
          end

          if (p1_hit || p2_hit) begin
            if (rally_q != 8'hff) rally_d = rally_q + 8'd1;
            if (32'(hit_cnt_q) + 32'd1 >= HITS_PER_SPEEDUP) begin
              hit_cnt_d = '0;
              if (32'(speed_q) + 32'd1 > MAX_SPEED) speed_d = 4'(MAX_SPEED);
              else                                  speed_d = speed_q + 4'd1;
            end else begin
              hit_cnt_d = hit_cnt_q + HitW'(1);
            end
          end
        end
      end

      StScored: begin
        // Serve back toward the player who conceded; vertical direction carries over.
        x_d         = StartX;
        y_d         = StartY;
        dx_d        = serve_dir_q;
        speed_d     = 4'd1;
        rally_d     = '0;
        hit_cnt_d   = '0;
        delay_cnt_d = '0;
        state_d     = StServeWait;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge game_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      x_q         <= StartX;
      y_q         <= StartY;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      serve_dir_q <= 1'b1;
      speed_q     <= 4'd1;
      rally_q     <= '0;
      hit_cnt_q   <= '0;
      delay_cnt_q <= '0;
      point_p1_q  <= 1'b0;
      point_p2_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      serve_dir_q <= serve_dir_d;
      speed_q     <= speed_d;
      rally_q     <= rally_d;
      hit_cnt_q   <= hit_cnt_d;
      delay_cnt_q <= delay_cnt_d;
      point_p1_q  <= point_p1_d;
      point_p2_q  <= point_p2_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign point_p1 = point_p1_q;
  assign point_p2 = point_p2_q;
  assign speed    = speed_q;
  assign rally    = rally_q;
  assign state    = state_q;

endmodule
